// File: rtl/intr_controller_if.sv
// Signal bundle between the CPU side and the interrupt controller.
// The controller connects through the slave modport.
interface intr_controller_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NCH   = 3
);
   logic [NCH-1:0]   irq_in;
   logic [NCH-1:0]   mask_in;
   logic             int_ack;
   logic             int_eret;
   logic             IntR;
   logic [2:0]       IntNo;
   logic [WIDTH-1:0] IntAddr;
   logic [NCH-1:0]   in_service;

   modport master (
      output irq_in, mask_in, int_ack, int_eret,
      input  IntR, IntNo, IntAddr, in_service
   );

   modport slave (
      input  irq_in, mask_in, int_ack, int_eret,
      output IntR, IntNo, IntAddr, in_service
   );
endinterface

// File: rtl/intr_controller.sv
// Fixed-priority nested interrupt controller: edge-latched pending requests,
// higher channel index wins, nesting only by strictly higher priority.
module intr_controller #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned NCH        = 3,
   parameter logic [31:0] VEC_BASE   = 32'h30ac,
   parameter logic [31:0] VEC_STRIDE = 32'ha4
) (
   input logic               clk,
   input logic               rst_n,
   intr_controller_if.slave  bus
);
   logic [NCH-1:0]   irq_d;
   logic [NCH-1:0]   pending;
   logic [NCH-1:0]   in_service;
   logic [NCH-1:0]   rise;
   logic [NCH-1:0]   ack_set;
   logic [NCH-1:0]   eret_clr;
   logic             cand_valid;
   logic [2:0]       cand_idx;
   logic             top_valid;
   logic [2:0]       top_idx;
   logic             fire;
   logic [WIDTH-1:0] addr;

   assign rise = bus.irq_in & ~irq_d;

   // Ascending scan: the last hit is the highest index.
   always_comb begin
      cand_valid = 1'b0;
      cand_idx   = '0;
      top_valid  = 1'b0;
      top_idx    = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (pending[i] && !bus.mask_in[i]) begin
            cand_valid = 1'b1;
            cand_idx   = 3'(i);
         end
         if (in_service[i]) begin
            top_valid = 1'b1;
            top_idx   = 3'(i);
         end
      end
   end

   always_comb begin
      fire     = cand_valid && (!top_valid || (cand_idx > top_idx));
      addr     = WIDTH'(VEC_BASE) + WIDTH'(cand_idx) * WIDTH'(VEC_STRIDE);
      ack_set  = (bus.int_ack && fire)   ? (NCH'(1) << cand_idx) : '0;
      eret_clr = (bus.int_eret && top_valid) ? (NCH'(1) << top_idx) : '0;
   end

   assign bus.IntR       = fire;
   assign bus.IntNo      = fire ? (cand_idx + 3'd1) : 3'd0;
   assign bus.IntAddr    = fire ? addr : '0;
   assign bus.in_service = in_service;

   // A fresh edge on the acked channel re-arms pending in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_d      <= '0;
         pending    <= '0;
         in_service <= '0;
      end else begin
         irq_d      <= bus.irq_in;
         pending    <= (pending & ~ack_set) | rise;
         in_service <= (in_service | ack_set) & ~eret_clr;
      end
   end
endmodule
